// File: rtl/cp0_reg_pkg.sv
// -----------------------------------------------------------------------------
// cp0_reg_pkg
//   Shared constants for the CP0 system-control register file:
//   - register addresses as seen on the mtc0/mfc0 address buses
//   - bit positions inside Status and Cause
//   - reset values of the writable registers
//   - a helper that merges a software write into Cause (only IP[9:8] writable)
// -----------------------------------------------------------------------------
package cp0_reg_pkg;

   // Register addresses
   localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_REG_EPC     = 5'd14;
   localparam logic [4:0] CP0_REG_PRID    = 5'd15;
   localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

   // Status / Cause field positions
   localparam int STATUS_EXL      = 1;
   localparam int CAUSE_BD        = 31;
   localparam int CAUSE_IP_HW_LO  = 10;
   localparam int CAUSE_IP_HW_HI  = 15;
   localparam int CAUSE_IP_SW_LO  = 8;
   localparam int CAUSE_IP_SW_HI  = 9;
   localparam int CAUSE_EXC_LO    = 2;
   localparam int CAUSE_EXC_HI    = 6;

   // Reset values
   localparam logic [31:0] COUNT_RESET   = 32'h0000_0000;
   localparam logic [31:0] COMPARE_RESET = 32'h0000_0000;
   localparam logic [31:0] STATUS_RESET  = 32'h1000_0000;
   localparam logic [31:0] CAUSE_RESET   = 32'h0000_0000;
   localparam logic [31:0] EPC_RESET     = 32'h0000_0000;

   // Value Cause takes when software writes it: only the two software
   // interrupt-pending bits come from the write data, the rest is kept.
   function automatic logic [31:0] cause_sw_merge(input logic [31:0] cur,
                                                  input logic [31:0] wdata);
      logic [31:0] res;
      res = cur;
      res[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] = wdata[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
      return res;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//   Count/Compare timer of CP0. Count increments every cycle (wrapping) unless
//   software loads it; a Count==Compare match (Compare non-zero, pre-increment
//   Count) raises a sticky timer interrupt that only a Compare write or reset
//   clears. A Compare write in the same cycle as a match wins (interrupt = 0).
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   count_we    in   load Count with wdata this cycle
//   compare_we  in   load Compare with wdata this cycle, clear interrupt
//   wdata       in   32-bit write data
//   count       out  current Count
//   compare     out  current Compare
//   timer_int   out  sticky timer interrupt
// -----------------------------------------------------------------------------
module cp0_timer
   import cp0_reg_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   logic [31:0] count_reg,   count_next;
   logic [31:0] compare_reg, compare_next;
   logic        timer_int_reg, timer_int_next;
   logic        match;

   assign match = (compare_reg != 32'd0) && (count_reg == compare_reg);

   always_comb begin
      count_next     = count_reg + 32'd1;
      compare_next   = compare_reg;
      timer_int_next = timer_int_reg;
      if (match) begin
         timer_int_next = 1'b1;
      end
      if (count_we) begin
         count_next = wdata;
      end
      // Ordered after the match so a Compare write clears a simultaneous hit.
      if (compare_we) begin
         compare_next   = wdata;
         timer_int_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_reg     <= COUNT_RESET;
         compare_reg   <= COMPARE_RESET;
         timer_int_reg <= 1'b0;
      end else begin
         count_reg     <= count_next;
         compare_reg   <= compare_next;
         timer_int_reg <= timer_int_next;
      end
   end

   assign count     = count_reg;
   assign compare   = compare_reg;
   assign timer_int = timer_int_reg;

endmodule

// File: rtl/cp0_reg.sv
// -----------------------------------------------------------------------------
// cp0_reg
//   CP0 system-control register file. Accepts the WB-stage mtc0 write port,
//   supplies combinational mfc0 read data to EX (with write bypass), takes
//   exception / eret events from MEM and exports Count, Compare, Status,
//   Cause, EPC and the timer interrupt to the exception controller.
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   we_i, waddr_i, data_i       CP0 write port
//   raddr_i, data_o             mfc0 read port (data_o combinational)
//   int_i                       hardware interrupt levels -> Cause.IP[15:10]
//   exc_valid_i, exc_code_i,
//   exc_pc_i, exc_in_delay_i    exception taken this cycle
//   eret_i                      eret committed this cycle
//   count_o .. epc_o            registered CP0 state
//   timer_int_o                 sticky Count==Compare interrupt
// -----------------------------------------------------------------------------
module cp0_reg
   import cp0_reg_pkg::*;
#(
   parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
   parameter int          INT_W      = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             we_i,
   input  logic [4:0]       waddr_i,
   input  logic [31:0]      data_i,
   input  logic [4:0]       raddr_i,
   input  logic [INT_W-1:0] int_i,
   input  logic             exc_valid_i,
   input  logic [4:0]       exc_code_i,
   input  logic [31:0]      exc_pc_i,
   input  logic             exc_in_delay_i,
   input  logic             eret_i,
   output logic [31:0]      data_o,
   output logic [31:0]      count_o,
   output logic [31:0]      compare_o,
   output logic [31:0]      status_o,
   output logic [31:0]      cause_o,
   output logic [31:0]      epc_o,
   output logic             timer_int_o
);

   logic [31:0] status_reg, status_next;
   logic [31:0] cause_reg,  cause_next;
   logic [31:0] epc_reg,    epc_next;

   logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic [31:0] count_cur, compare_cur;
   logic rd_bypass;

   assign wr_count   = we_i && (waddr_i == CP0_REG_COUNT);
   assign wr_compare = we_i && (waddr_i == CP0_REG_COMPARE);
   assign wr_status  = we_i && (waddr_i == CP0_REG_STATUS);
   assign wr_cause   = we_i && (waddr_i == CP0_REG_CAUSE);
   assign wr_epc     = we_i && (waddr_i == CP0_REG_EPC);

   cp0_timer u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (data_i),
      .count      (count_cur),
      .compare    (compare_cur),
      .timer_int  (timer_int_o)
   );

   // Next-state: software write first, then exception / eret on top of it.
   always_comb begin
      status_next = status_reg;
      cause_next  = cause_reg;
      epc_next    = epc_reg;

      // Hardware interrupt lines are sampled into Cause every cycle.
      cause_next[CAUSE_IP_HW_LO +: INT_W] = int_i;

      if (wr_status) begin
         status_next = data_i;
      end
      if (wr_cause) begin
         cause_next[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] = data_i[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
      end
      if (wr_epc) begin
         epc_next = data_i;
      end

      if (exc_valid_i) begin
         // A nested exception (EXL already set) keeps the original EPC/BD so
         // the handler can still return to the first faulting instruction.
         if (!status_reg[STATUS_EXL]) begin
            epc_next            = exc_in_delay_i ? (exc_pc_i - 32'd4) : exc_pc_i;
            cause_next[CAUSE_BD] = exc_in_delay_i;
         end
         status_next[STATUS_EXL]               = 1'b1;
         cause_next[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_i;
      end else if (eret_i) begin
         status_next[STATUS_EXL] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_reg <= STATUS_RESET;
         cause_reg  <= CAUSE_RESET;
         epc_reg    <= EPC_RESET;
      end else begin
         status_reg <= status_next;
         cause_reg  <= cause_next;
         epc_reg    <= epc_next;
      end
   end

   // mfc0 read. A same-cycle write to the read address is forwarded so EX
   // sees the value the WB write is about to commit.
   assign rd_bypass = we_i && (waddr_i == raddr_i);

   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         CP0_REG_COUNT:   data_o = rd_bypass ? data_i : count_cur;
         CP0_REG_COMPARE: data_o = rd_bypass ? data_i : compare_cur;
         CP0_REG_STATUS:  data_o = rd_bypass ? data_i : status_reg;
         CP0_REG_CAUSE:   data_o = rd_bypass ? cause_sw_merge(cause_reg, data_i) : cause_reg;
         CP0_REG_EPC:     data_o = rd_bypass ? data_i : epc_reg;
         CP0_REG_PRID:    data_o = PRID_VAL;
         CP0_REG_CONFIG:  data_o = CONFIG_VAL;
         default:         data_o = 32'd0;
      endcase
   end

   assign count_o   = count_cur;
   assign compare_o = compare_cur;
   assign status_o  = status_reg;
   assign cause_o   = cause_reg;
   assign epc_o     = epc_reg;

endmodule

// File: tb/tb_cp0_reg.sv
module tb_cp0_reg;

   localparam logic [31:0] PRID   = 32'h0048_0102;
   localparam logic [31:0] CONFIG = 32'h0000_8000;

   typedef struct packed {
      logic [31:0] count;
      logic [31:0] compare;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc;
      logic        tint;
   } st_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr;
      logic [5:0]  intl;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        dly;
      logic        eret;
   } stim_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        we_i = 1'b0;
   logic [4:0]  waddr_i = '0;
   logic [31:0] data_i = '0;
   logic [4:0]  raddr_i = '0;
   logic [5:0]  int_i = '0;
   logic        exc_valid_i = 1'b0;
   logic [4:0]  exc_code_i = '0;
   logic [31:0] exc_pc_i = '0;
   logic        exc_in_delay_i = 1'b0;
   logic        eret_i = 1'b0;
   logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o;
   logic        timer_int_o;

   always #5 clk = ~clk;

   cp0_reg #(.PRID_VAL(PRID), .CONFIG_VAL(CONFIG), .INT_W(6)) dut (
      .clk(clk), .resetn(resetn), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
      .raddr_i(raddr_i), .int_i(int_i), .exc_valid_i(exc_valid_i),
      .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_in_delay_i(exc_in_delay_i),
      .eret_i(eret_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   st_t         m;          // reference state after the last issued stimulus
   st_t         exp_q[$];   // expected registered state, one per cycle
   logic [31:0] rd_q[$];    // expected combinational read data, one per cycle
   st_t         st_e;
   logic [31:0] rd_e;

   localparam st_t RESET_ST = '{count: 32'd0, compare: 32'd0, status: 32'h1000_0000,
                                cause: 32'd0, epc: 32'd0, tint: 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: what mfc0 must return for the current state and this cycle's inputs.
   function automatic logic [31:0] exp_read(input st_t s, input stim_t x);
      logic byp;
      byp = x.we && (x.waddr == x.raddr);
      case (x.raddr)
         5'd9:  return byp ? x.wdata : s.count;
         5'd11: return byp ? x.wdata : s.compare;
         5'd12: return byp ? x.wdata : s.status;
         5'd13: return byp ? ((s.cause & ~32'h300) | (x.wdata & 32'h300)) : s.cause;
         5'd14: return byp ? x.wdata : s.epc;
         5'd15: return PRID;
         5'd16: return CONFIG;
         default: return 32'd0;
      endcase
   endfunction

   // Reference: CP0 state one clock edge later.
   function automatic st_t model_next(input st_t s, input stim_t x);
      st_t n;
      n = s;
      n.count = s.count + 32'd1;
      n.cause = (s.cause & ~32'h0000_FC00) | ({26'd0, x.intl} << 10);
      if (s.compare != 0 && s.count == s.compare) n.tint = 1'b1;
      if (x.we) begin
         case (x.waddr)
            5'd9:  n.count = x.wdata;
            5'd11: begin n.compare = x.wdata; n.tint = 1'b0; end
            5'd12: n.status = x.wdata;
            5'd13: n.cause = (n.cause & ~32'h300) | (x.wdata & 32'h300);
            5'd14: n.epc = x.wdata;
            default: ;
         endcase
      end
      if (x.exc) begin
         if (s.status[1] == 1'b0) begin
            n.epc = x.dly ? x.pc - 32'd4 : x.pc;
            n.cause[31] = x.dly;
         end
         n.status[1] = 1'b1;
         n.cause = (n.cause & ~32'h7C) | ({27'd0, x.code} << 2);
      end else if (x.eret) begin
         n.status[1] = 1'b0;
      end
      return n;
   endfunction

   function automatic stim_t idle(input logic [4:0] ra);
      stim_t x;
      x = '0;
      x.raddr = ra;
      return x;
   endfunction

   function automatic logic [4:0] pick_addr();
      logic [4:0] tbl [8];
      tbl = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
      return tbl[$urandom_range(0, 7)];
   endfunction

   function automatic stim_t rand_stim();
      stim_t x;
      x.we    = ($urandom_range(0, 3) == 0);
      x.waddr = pick_addr();
      x.raddr = ($urandom_range(0, 3) == 0) ? x.waddr : pick_addr();
      x.wdata = $urandom;
      if (x.waddr == 5'd11 && $urandom_range(0, 1) == 1)
         x.wdata = m.count + $urandom_range(1, 20);
      if (x.waddr == 5'd9 && $urandom_range(0, 1) == 1)
         x.wdata = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      x.intl  = 6'($urandom);
      x.exc   = ($urandom_range(0, 15) == 0);
      x.code  = 5'($urandom);
      x.pc    = {$urandom} & 32'hFFFF_FFFC;
      x.dly   = 1'($urandom);
      x.eret  = ($urandom_range(0, 15) == 0);
      return x;
   endfunction

   // Issue one cycle of stimulus at the falling edge and queue its expectations.
   task automatic drive(input stim_t x);
      @(negedge clk);
      we_i = x.we; waddr_i = x.waddr; data_i = x.wdata; raddr_i = x.raddr;
      int_i = x.intl; exc_valid_i = x.exc; exc_code_i = x.code; exc_pc_i = x.pc;
      exc_in_delay_i = x.dly; eret_i = x.eret;
      rd_q.push_back(exp_read(m, x));
      m = model_next(m, x);
      exp_q.push_back(m);
   endtask

   // Wait past the edge that commits the last driven stimulus.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Asynchronous reset pulse between edges; outputs must clear immediately.
   task automatic do_reset();
      @(posedge clk);
      #2;
      resetn = 1'b0;
      we_i = 0; exc_valid_i = 0; eret_i = 0; int_i = '0;
      #1;
      chk("rst count", count_o, 32'd0);
      chk("rst compare", compare_o, 32'd0);
      chk("rst status", status_o, 32'h1000_0000);
      chk("rst cause", cause_o, 32'd0);
      chk("rst epc", epc_o, 32'd0);
      chk("rst timer_int", {31'd0, timer_int_o}, 32'd0);
      m = RESET_ST;
      resetn = 1'b1;
   endtask

   // Read monitor: combinational mfc0 data, sampled mid low phase.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rd_q.size() > 0) begin
            rd_e = rd_q.pop_front();
            chk("data_o", data_o, rd_e);
         end
      end
   end

   // State monitor: registered outputs, sampled just after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            st_e = exp_q.pop_front();
            chk("count_o", count_o, st_e.count);
            chk("compare_o", compare_o, st_e.compare);
            chk("status_o", status_o, st_e.status);
            chk("cause_o", cause_o, st_e.cause);
            chk("epc_o", epc_o, st_e.epc);
            chk("timer_int_o", {31'd0, timer_int_o}, {31'd0, st_e.tint});
         end
      end
   end

   initial begin
      stim_t x;
      m = RESET_ST;
      do_reset();

      // Compare=10 written while count==3, then reach count 5 reading PRId.
      repeat (3) drive(idle(5'd9));
      x = idle(5'd9); x.we = 1; x.waddr = 5'd11; x.wdata = 32'd10;
      drive(x);
      drive(idle(5'd15));
      settle();
      chk("count after 5", count_o, 32'd5);
      chk("status after 5", status_o, 32'h1000_0000);
      chk("prid read", data_o, PRID);
      repeat (5) drive(idle(5'd9));
      settle();
      chk("count at 10", count_o, 32'd10);
      chk("tint before match", {31'd0, timer_int_o}, 32'd0);
      drive(idle(5'd9));
      settle();
      chk("tint after match", {31'd0, timer_int_o}, 32'd1);
      x = idle(5'd11); x.we = 1; x.waddr = 5'd11; x.wdata = 32'd20;
      drive(x);
      settle();
      chk("tint cleared", {31'd0, timer_int_o}, 32'd0);

      // Count wrap.
      x = idle(5'd9); x.we = 1; x.waddr = 5'd9; x.wdata = 32'hFFFF_FFFE;
      drive(x);
      drive(idle(5'd9));
      settle();
      chk("count ffffffff", count_o, 32'hFFFF_FFFF);
      drive(idle(5'd9));
      settle();
      chk("count wrap 0", count_o, 32'd0);

      // Cause write: only software IP bits, hardware IP from int_i.
      x = idle(5'd13); x.we = 1; x.waddr = 5'd13; x.wdata = 32'hFFFF_FFFF; x.intl = 6'b000001;
      drive(x);
      settle();
      chk("cause write", cause_o, 32'h0000_0700);

      // Exception in delay slot, nested exception, eret.
      x = idle(5'd14); x.exc = 1; x.pc = 32'h100; x.dly = 1; x.code = 5'h0C;
      drive(x);
      settle();
      chk("exc epc", epc_o, 32'hFC);
      chk("exc bd", {31'd0, cause_o[31]}, 32'd1);
      chk("exc code", {27'd0, cause_o[6:2]}, 32'h0C);
      chk("exc exl", {31'd0, status_o[1]}, 32'd1);
      x = idle(5'd14); x.exc = 1; x.pc = 32'h200; x.dly = 0; x.code = 5'h04;
      drive(x);
      settle();
      chk("nested epc", epc_o, 32'hFC);
      x = idle(5'd12); x.eret = 1;
      drive(x);
      settle();
      chk("eret exl", {31'd0, status_o[1]}, 32'd0);

      // Read bypass, then EPC write overridden by exception.
      x = idle(5'd14); x.we = 1; x.waddr = 5'd14; x.wdata = 32'hABCD;
      drive(x);
      #1;
      chk("bypass epc", data_o, 32'hABCD);
      x = idle(5'd14); x.we = 1; x.waddr = 5'd14; x.wdata = 32'h1234; x.exc = 1;
      x.pc = 32'h40; x.dly = 0;
      drive(x);
      settle();
      chk("exc over write", epc_o, 32'h40);

      // Randomized traffic with occasional mid-run resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         drive(rand_stim());
      end
      drive(idle(5'd0));
      settle();
      chk("queues drained", exp_q.size() + rd_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
